// File: rtl/traffic_light_fsm.sv
// Two-road lamp sequencer following the phase counter's ctrl, with pedestrian extension and watchdog fault.
// Outputs are registered and lag ctrl by one clk; no backpressure, and every ctrl edge is consumed when it is seen.
module traffic_light_fsm #(
  parameter int WDOG_CYCLES = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ctrl,
  input  logic       ped_btn,
  output logic       request,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_pending,
  output logic       fault
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    EW_GREEN  = 3'd2,
    EW_YELLOW = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [4:0] WDOG_LAST   = 5'(WDOG_CYCLES - 1);

  state_t     state, state_nxt;
  logic       ped_s1, ped_s2, ped_s3;
  logic       ped_rise;
  logic       ctrl_q;
  logic       ctrl_fall, ctrl_rise, ctrl_edge;
  logic [4:0] wdog_cnt;
  logic       wdog_expire;
  logic       load;
  logic       ped_accept;
  logic       request_nxt, walk_nxt, pending_nxt, fault_nxt;
  logic [2:0] ns_nxt, ew_nxt;

  // ped_s3 is only the edge-detect history of the synchronized button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_s1 <= 1'b0;
      ped_s2 <= 1'b0;
      ped_s3 <= 1'b0;
    end else begin
      ped_s1 <= ped_btn;
      ped_s2 <= ped_s1;
      ped_s3 <= ped_s2;
    end
  end

  assign ped_rise = ped_s2 & ~ped_s3;

  // ctrl_q resets high so the counter's initial 1 never looks like a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= 1'b1;
    end else begin
      ctrl_q <= ctrl;
    end
  end

  assign ctrl_fall = ctrl_q & ~ctrl;
  assign ctrl_rise = ~ctrl_q & ctrl;
  assign ctrl_edge = ctrl_fall | ctrl_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= 5'd0;
    end else if (fault) begin
      wdog_cnt <= wdog_cnt;
    end else if (ctrl_edge) begin
      wdog_cnt <= 5'd0;
    end else begin
      wdog_cnt <= wdog_cnt + 5'd1;
    end
  end

  // A ctrl edge in the expiry cycle keeps the controller alive.
  assign wdog_expire = (state != FAULT) & ~ctrl_edge & (wdog_cnt == WDOG_LAST);

  assign load       = ctrl_rise & ((state == NS_YELLOW) | (state == EW_YELLOW));
  assign ped_accept = ped_rise & ~walk & (state != FAULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= NS_GREEN;
      ns_light    <= LAMP_GREEN;
      ew_light    <= LAMP_RED;
      request     <= 1'b0;
      walk        <= 1'b0;
      ped_pending <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      ns_light    <= ns_nxt;
      ew_light    <= ew_nxt;
      request     <= request_nxt;
      walk        <= walk_nxt;
      ped_pending <= pending_nxt;
      fault       <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (wdog_expire) begin
      state_nxt = FAULT;
    end else begin
      case (state)
        NS_GREEN:  if (ctrl_fall) state_nxt = NS_YELLOW;
        NS_YELLOW: if (ctrl_rise) state_nxt = EW_GREEN;
        EW_GREEN:  if (ctrl_fall) state_nxt = EW_YELLOW;
        EW_YELLOW: if (ctrl_rise) state_nxt = NS_GREEN;
        FAULT:     state_nxt = FAULT;
        default:   state_nxt = FAULT;
      endcase
    end
  end

  // request only changes at yellow-to-green so the counter's wrap compare stays stable.
  always_comb begin
    request_nxt = request;
    pending_nxt = ped_pending;
    fault_nxt   = fault;
    if (wdog_expire) begin
      request_nxt = 1'b0;
      pending_nxt = 1'b0;
      fault_nxt   = 1'b1;
    end else if (load) begin
      request_nxt = ped_pending | ped_accept;
      pending_nxt = 1'b0;
    end else if (ped_accept) begin
      pending_nxt = 1'b1;
    end

    walk_nxt = ((state_nxt == NS_GREEN) | (state_nxt == EW_GREEN)) & request_nxt;

    ns_nxt = LAMP_RED;
    ew_nxt = LAMP_RED;
    case (state_nxt)
      NS_GREEN:  ns_nxt = LAMP_GREEN;
      NS_YELLOW: ns_nxt = LAMP_YELLOW;
      EW_GREEN:  ew_nxt = LAMP_GREEN;
      EW_YELLOW: ew_nxt = LAMP_YELLOW;
      default:   begin
        ns_nxt = LAMP_RED;
        ew_nxt = LAMP_RED;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench: a behavioural phase counter drives ctrl; checks lamp timing, pedestrian extension and watchdog.
module tb_traffic_light_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ctrl;
  logic       ped_btn;
  logic       request;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_pending;
  logic       fault;

  int n_checks = 0;
  int n_errors = 0;
  int edge_n   = 0;
  int cnt      = 0;
  bit run_ctr  = 1'b0;

  traffic_light_fsm #(.WDOG_CYCLES(24)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ctrl        (ctrl),
    .ped_btn     (ped_btn),
    .request     (request),
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .walk        (walk),
    .ped_pending (ped_pending),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s@e%0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  // One clk edge; the phase-counter model advances just after it.
  task automatic step();
    int g;
    @(posedge clk);
    #1;
    edge_n++;
    if (run_ctr) begin
      g = request ? 15 : 10;
      if (cnt == g + 2) cnt = 0;
      else cnt++;
      ctrl = (cnt < g);
    end
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) step();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ns"},   8'(ns_light),    8'h01);
    check({tag, "_ew"},   8'(ew_light),    8'h04);
    check({tag, "_req"},  8'(request),     8'h00);
    check({tag, "_walk"}, 8'(walk),        8'h00);
    check({tag, "_pend"}, 8'(ped_pending), 8'h00);
    check({tag, "_flt"},  8'(fault),       8'h00);
  endtask

  task automatic apply_reset(input bit ctr_on);
    rst_n   = 1'b0;
    ctrl    = 1'b1;
    ped_btn = 1'b0;
    cnt     = 0;
    run_ctr = ctr_on;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    logic [2:0] exp_ns, exp_ew;

    // Run 1: paired with the counter, no button.
    apply_reset(1'b1);
    check_reset_vals("rst0");
    for (int e = 1; e <= 27; e++) begin
      step();
      exp_ns = (e <= 10) ? 3'b001 : (e <= 13) ? 3'b010 : (e <= 26) ? 3'b100 : 3'b001;
      exp_ew = (e <= 13) ? 3'b100 : (e <= 23) ? 3'b001 : (e <= 26) ? 3'b010 : 3'b100;
      check("seq_ns", 8'(ns_light), 8'(exp_ns));
      check("seq_ew", 8'(ew_light), 8'(exp_ew));
      check("seq_req", 8'(request), 8'h00);
    end

    // Run 2: pedestrian extension, ignored press, press coincident with rise, reset mid-phase.
    apply_reset(1'b1);
    run_to(5);
    ped_btn = 1'b1;
    run_to(7);
    ped_btn = 1'b0;
    check("pend_e7", 8'(ped_pending), 8'h00);
    run_to(8);
    check("pend_e8", 8'(ped_pending), 8'h01);
    run_to(13);
    check("req_e13", 8'(request), 8'h00);
    run_to(14);
    check("ext_req",  8'(request),     8'h01);
    check("ext_pend", 8'(ped_pending), 8'h00);
    check("ext_walk", 8'(walk),        8'h01);
    check("ext_ew",   8'(ew_light),    8'h01);

    run_to(18);
    ped_btn = 1'b1;
    run_to(20);
    ped_btn = 1'b0;
    run_to(22);
    check("walk_press_pend", 8'(ped_pending), 8'h00);

    run_to(28);
    check("ext_last_ew",   8'(ew_light), 8'h01);
    check("ext_last_walk", 8'(walk),     8'h01);
    run_to(29);
    check("ew_yel",      8'(ew_light), 8'h02);
    check("ew_yel_walk", 8'(walk),     8'h00);
    check("ew_yel_req",  8'(request),  8'h01);
    run_to(32);
    check("ns_back",     8'(ns_light), 8'h01);
    check("ns_back_req", 8'(request),  8'h00);
    run_to(41);
    check("noext_ns41", 8'(ns_light), 8'h01);
    run_to(42);
    check("noext_ns42", 8'(ns_light), 8'h02);

    ped_btn = 1'b1;
    run_to(44);
    ped_btn = 1'b0;
    check("coin_pend44", 8'(ped_pending), 8'h00);
    run_to(45);
    check("coin_req",  8'(request),     8'h01);
    check("coin_pend", 8'(ped_pending), 8'h00);
    check("coin_walk", 8'(walk),        8'h01);
    check("coin_ew",   8'(ew_light),    8'h01);

    run_to(50);
    check("pre_rst_req", 8'(request), 8'h01);
    rst_n = 1'b0;
    #2;
    check_reset_vals("midrst");
    apply_reset(1'b1);
    run_to(10);
    check("post_ns10", 8'(ns_light), 8'h01);
    run_to(11);
    check("post_ns11", 8'(ns_light), 8'h02);
    run_to(14);
    check("post_ew14", 8'(ew_light), 8'h01);
    check("post_req",  8'(request),  8'h00);

    // Run 3: ctrl stuck high from reset trips the watchdog.
    apply_reset(1'b0);
    run_to(23);
    check("wd_e23_flt", 8'(fault),    8'h00);
    check("wd_e23_ns",  8'(ns_light), 8'h01);
    run_to(24);
    check("wd_flt",  8'(fault),    8'h01);
    check("wd_ns",   8'(ns_light), 8'h04);
    check("wd_ew",   8'(ew_light), 8'h04);
    check("wd_walk", 8'(walk),     8'h00);
    ctrl = 1'b0;
    run_to(27);
    ctrl = 1'b1;
    run_to(30);
    check("sticky_flt", 8'(fault),    8'h01);
    check("sticky_ns",  8'(ns_light), 8'h04);
    check("sticky_ew",  8'(ew_light), 8'h04);
    rst_n = 1'b0;
    #2;
    check_reset_vals("flt_rst");

    // Run 4: edge arriving in the expiry cycle wins, then ctrl stuck low expires.
    apply_reset(1'b0);
    run_to(23);
    ctrl = 1'b0;
    run_to(24);
    check("race_flt", 8'(fault),    8'h00);
    check("race_ns",  8'(ns_light), 8'h02);
    run_to(47);
    check("low_e47_flt", 8'(fault), 8'h00);
    run_to(48);
    check("low_e48_flt", 8'(fault),    8'h01);
    check("low_e48_ns",  8'(ns_light), 8'h04);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
